// File: rtl/aes_result_display.sv
// Latches the AES ciphertext on done, stretches done into a visible indication,
// and shows one nibble at a time on the LEDs, stepped by a debounced push-button.
module aes_result_display #(
  parameter int DATA_W          = 128,
  parameter int HOLD_CYCLES     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         done_i,
  input  logic [DATA_W-1:0]            ct_i,
  input  logic                         btn_i,
  output logic [3:0]                   led_o,
  output logic                         done_latched_o,
  output logic                         valid_o,
  output logic [$clog2(DATA_W/4)-1:0]  nib_idx_o
);

  localparam int NIB_N  = DATA_W / 4;
  localparam int IDX_W  = $clog2(NIB_N);
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NIB_N - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_SHOW  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] ct_q, ct_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              db_q, db_d;
  logic              step;

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d  = btn_i;
    sync2_d  = sync1_q;
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync2_q != db_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign step = db_d & ~db_q;

  always_comb begin
    state_d    = state_q;
    ct_d       = ct_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    if (done_i) begin
      // A capture always wins over a coincident step and restarts the full hold window.
      ct_d       = ct_i;
      idx_d      = '0;
      hold_cnt_d = HOLD_LAST;
      state_d    = ST_HOLD;
    end else begin
      if (step && (state_q != ST_EMPTY)) begin
        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
      if (state_q == ST_HOLD) begin
        if (hold_cnt_q == '0) begin
          state_d = ST_SHOW;
        end else begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      ct_q       <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      db_cnt_q   <= '0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ct_q       <= ct_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      db_cnt_q   <= db_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_q       <= db_d;
    end
  end

  assign valid_o        = (state_q != ST_EMPTY);
  assign done_latched_o = (state_q == ST_HOLD);
  assign nib_idx_o      = idx_q;
  assign led_o          = valid_o ? ct_q[DATA_W-1-4*int'(idx_q) -: 4] : 4'h0;

endmodule

// File: tb/tb_aes_result_display.sv
// Scoreboard bench for aes_result_display: stimulus queues expected outputs,
// a monitor pops and compares them shortly after each rising clock edge.
module tb_aes_result_display;

  localparam int DATA_W = 128;
  localparam int HOLD   = 8;
  localparam int DEB    = 4;
  localparam logic [127:0] CT_A = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] CT_B = {4'hF, 124'h0};

  logic         clk    = 1'b0;
  logic         rst_n  = 1'b0;
  logic         done_i = 1'b0;
  logic         btn_i  = 1'b0;
  logic [127:0] ct_i   = '0;
  logic [3:0]   led_o;
  logic         done_latched_o;
  logic         valid_o;
  logic [4:0]   nib_idx_o;

  aes_result_display #(
    .DATA_W(DATA_W), .HOLD_CYCLES(HOLD), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .done_i(done_i), .ct_i(ct_i), .btn_i(btn_i),
    .led_o(led_o), .done_latched_o(done_latched_o), .valid_o(valid_o),
    .nib_idx_o(nib_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit [3:0]   mask;   // [3] led, [2] idx, [1] valid, [0] done_latched
    logic [3:0] led;
    logic [4:0] idx;
    logic       vld;
    logic       dl;
  } exp_t;

  exp_t  sb_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  string HEX   = "0123456789ABCDEFFEDCBA9876543210";

  function automatic logic [3:0] hexnib(int k);
    logic [7:0] c;
    c = HEX[k];
    if (c >= 8'h41) return 4'(c - 8'h37);
    return 4'(c - 8'h30);
  endfunction

  function automatic exp_t mk(string nm, bit [3:0] m, logic [3:0] led, logic [4:0] idx,
                              logic v, logic dl);
    exp_t e;
    e.name = nm; e.mask = m; e.led = led; e.idx = idx; e.vld = v; e.dl = dl;
    return e;
  endfunction

  task automatic check_field(string nm, string fld, int act, int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s.%s at %0t: got %0h, want %0h", nm, fld, $time, act, req);
    end
  endtask

  task automatic check_exp(exp_t e);
    if (e.mask[3]) check_field(e.name, "led_o",          int'(led_o),          int'(e.led));
    if (e.mask[2]) check_field(e.name, "nib_idx_o",      int'(nib_idx_o),      int'(e.idx));
    if (e.mask[1]) check_field(e.name, "valid_o",        int'(valid_o),        int'(e.vld));
    if (e.mask[0]) check_field(e.name, "done_latched_o", int'(done_latched_o), int'(e.dl));
  endtask

  // Expectation for the outputs after the next rising edge; called at a falling edge.
  task automatic expect_next(exp_t e);
    sb_q.push_back(e);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(int hi, int lo);
    btn_i = 1'b1;
    cycles(hi);
    btn_i = 1'b0;
    cycles(lo);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      while (sb_q.size() > 0) check_exp(sb_q.pop_front());
    end
  end

  initial begin
    #1_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1;
    check_exp(mk("reset_state", 4'hF, 4'h0, 5'd0, 1'b0, 1'b0));
    cycles(2);
    rst_n = 1'b1;

    // 1: EMPTY ignores clean presses
    for (int i = 0; i < 34; i++) begin
      btn_i = ((i >= 2 && i < 10) || (i >= 18 && i < 26)) ? 1'b1 : 1'b0;
      expect_next(mk("empty_idle", 4'hF, 4'h0, 5'd0, 1'b0, 1'b0));
      @(negedge clk);
    end

    // 2: capture and exact hold length
    done_i = 1'b1; ct_i = CT_A;
    expect_next(mk("capture", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
    @(negedge clk);
    done_i = 1'b0; ct_i = '0;
    for (int i = 1; i < HOLD; i++) begin
      expect_next(mk("hold_window", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
      @(negedge clk);
    end
    expect_next(mk("hold_expire", 4'hF, 4'h0, 5'd0, 1'b1, 1'b0));
    @(negedge clk);
    expect_next(mk("show_stays", 4'hF, 4'h0, 5'd0, 1'b1, 1'b0));
    @(negedge clk);

    // 3: 32 clean presses walk the nibbles MSB first and wrap
    for (int k = 1; k <= 32; k++) begin
      press(10, 10);
      expect_next(mk("step_seq", 4'hF, hexnib(k % 32), 5'(k % 32), 1'b1, 1'b0));
      @(negedge clk);
    end

    // 4: bouncy press gives one step; isolated 3-cycle pulse gives none
    btn_i = 1'b1; cycles(1); btn_i = 1'b0; cycles(1);
    btn_i = 1'b1; cycles(2); btn_i = 1'b0; cycles(1);
    btn_i = 1'b1; cycles(3); btn_i = 1'b0; cycles(2);
    btn_i = 1'b1; cycles(6); btn_i = 1'b0; cycles(10);
    expect_next(mk("bouncy_press", 4'hF, hexnib(1), 5'd1, 1'b1, 1'b0));
    @(negedge clk);
    press(3, 10);
    expect_next(mk("glitch_reject", 4'hF, hexnib(1), 5'd1, 1'b1, 1'b0));
    @(negedge clk);

    // 5: capture at idx=3 resets idx; retrigger at hold cycle 5 gives 13 cycles high
    press(10, 10);
    press(10, 10);
    expect_next(mk("idx_three", 4'hF, hexnib(3), 5'd3, 1'b1, 1'b0));
    @(negedge clk);
    done_i = 1'b1; ct_i = CT_A;
    expect_next(mk("recapture", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
    @(negedge clk);
    done_i = 1'b0;
    for (int i = 1; i < 5; i++) begin
      expect_next(mk("pre_retrig", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
      @(negedge clk);
    end
    done_i = 1'b1; ct_i = CT_B;
    expect_next(mk("retrigger", 4'hF, 4'hF, 5'd0, 1'b1, 1'b1));
    @(negedge clk);
    done_i = 1'b0; ct_i = '0;
    for (int i = 1; i < HOLD; i++) begin
      expect_next(mk("retrig_hold", 4'hF, 4'hF, 5'd0, 1'b1, 1'b1));
      @(negedge clk);
    end
    expect_next(mk("retrig_expire", 4'hF, 4'hF, 5'd0, 1'b1, 1'b0));
    @(negedge clk);

    // 6: step lands inside HOLD, then async reset mid-HOLD
    btn_i = 1'b1;
    @(negedge clk);
    done_i = 1'b1; ct_i = CT_A;
    expect_next(mk("cap_before_step", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
    @(negedge clk);
    done_i = 1'b0; ct_i = '0;
    for (int i = 0; i < 3; i++) begin
      expect_next(mk("hold_no_step", 4'hF, 4'h0, 5'd0, 1'b1, 1'b1));
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      expect_next(mk("step_in_hold", 4'hF, hexnib(1), 5'd1, 1'b1, 1'b1));
      @(negedge clk);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_exp(mk("async_reset", 4'hF, 4'h0, 5'd0, 1'b0, 1'b0));
    cycles(2);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      expect_next(mk("empty_held_btn", 4'hF, 4'h0, 5'd0, 1'b0, 1'b0));
      @(negedge clk);
    end
    btn_i = 1'b0;
    cycles(10);
    press(10, 10);
    expect_next(mk("empty_after_reset", 4'hF, 4'h0, 5'd0, 1'b0, 1'b0));
    cycles(3);
    check_field("scoreboard", "pending", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
